register_file_2r1w: RTL and testbench
=====================================

REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
Parameters, one per line: name, default, meaning.
- REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width in bits.
- REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; it matches the 5-bit destination-select mux output.
- REQ-003 The block SHALL have parameter BYPASS, default 1, meaning that 1 enables same-cycle write-to-read forwarding and 0 disables it.

Ports, one per line: name, direction, width, meaning (clock and reset first).
- REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
- REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
- REQ-006 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
- REQ-007 The block SHALL have port we, input, 1, meaning write enable.
- REQ-008 The block SHALL have port wa, input, ADDR_W, meaning write address, driven by the destination-select mux.
- REQ-009 The block SHALL have port wd, input, DATA_W, meaning write data.
- REQ-010 The block SHALL have port ra1, input, ADDR_W, meaning read address for port 1 (rs).
- REQ-011 The block SHALL have port ra2, input, ADDR_W, meaning read address for port 2 (rt).
- REQ-012 The block SHALL have port rd1, output, DATA_W, meaning read data for port 1.
- REQ-013 The block SHALL have port rd2, output, DATA_W, meaning read data for port 2.
- REQ-014 The block SHALL have port dbg_ra, input, ADDR_W, meaning debug read address.
- REQ-015 The block SHALL have port dbg_rd, output, DATA_W, meaning debug read data; this port is never bypassed.
- REQ-016 The block SHALL have port wr_cnt, output, 16, meaning a count of committed writes.

Function
- REQ-017 Storage SHALL be 2^ADDR_W entries of DATA_W bits; entry 0 SHALL always read as 0 and SHALL never be stored to.
- REQ-018 A write SHALL commit on the rising edge of clk when we=1 and wa!=0; wd lands in entry wa.
- REQ-019 A write with we=1 and wa=0 SHALL be discarded, with no storage change and no wr_cnt increment.
- REQ-020 Reads SHALL be combinational: rdN = entry[raN] with zero-cycle latency.
- REQ-021 With BYPASS=1, when we=1, wa!=0 and raN==wa, rdN SHALL equal wd in the same cycle, before the edge.
- REQ-022 With BYPASS=0, rdN SHALL return the old stored value until the edge, and the new value after it.
- REQ-023 Bypass SHALL apply independently to each port; both ports reading wa SHALL both receive wd.
- REQ-024 raN==0 SHALL yield 0 even when we=1 and wa=0 with nonzero wd.
- REQ-025 wr_cnt SHALL increment by 1 per committed write and wrap from 16'hFFFF to 16'h0000.
- REQ-026 X or Z on wa while we=0 SHALL cause no storage change.

Reset
- REQ-027 On assertion of rst_n=0, all entries and wr_cnt SHALL clear to 0 immediately, without waiting for a clock edge.
- REQ-028 While rst_n=0, writes SHALL be ignored and rd1, rd2 and dbg_rd SHALL read 0, with bypass suppressed.
- REQ-029 When rst_n deasserts with we=1, no write SHALL occur at that edge unless rst_n was high at that edge; rst_n is synchronized externally.
- REQ-030 Reset asserted mid-operation SHALL discard any write presented in that cycle.

Verification
- REQ-031 Reset scenario: rst_n=0, then ra1=5, ra2=31 -> rd1=0, rd2=0, wr_cnt=0.
- REQ-032 Write/read scenario: we=1, wa=8, wd=32'hDEADBEEF, one edge, then we=0, ra1=8 -> rd1=32'hDEADBEEF, wr_cnt=1.
- REQ-033 Zero-register scenario: we=1, wa=0, wd=32'h12345678, edge, ra1=0 -> rd1=0, wr_cnt unchanged.
- REQ-034 Bypass scenario with BYPASS=1: entry 9 holds 32'h1, we=1, wa=9, wd=32'hA5A5A5A5, ra1=ra2=9 before the edge -> rd1=rd2=32'hA5A5A5A5 and dbg_rd (dbg_ra=9)=32'h1; after the edge dbg_rd=32'hA5A5A5A5.
- REQ-035 Async reset scenario: entry 3 holds 32'hFF, rst_n is pulsed low between edges -> dbg_rd (dbg_ra=3)=0 at once, with no clock edge required.
- REQ-036 Counter wrap scenario: wr_cnt is preloaded to 16'hFFFF via 65535 writes to wa=1, then one more write -> wr_cnt=16'h0000.

Source files
------------

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - two-read one-write register file with zero entry, optional bypass and write counter
module register_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_rd,
    output logic [15:0]       wr_cnt
);

    localparam int NUM_ENTRIES = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NUM_ENTRIES];
    logic              commit;

    // Entry 0 is reset but never written, so it reads as zero from storage too.
    assign commit = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem[i] <= '0;
            end
            wr_cnt <= '0;
        end else if (commit) begin
            mem[wa] <= wd;
            wr_cnt  <= wr_cnt + 16'd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra, input logic allow_bypass);
        logic [DATA_W-1:0] val;
        val = '0;
        if (rst_n && (ra != '0)) begin
            if (allow_bypass && commit && (wa == ra)) begin
                val = wd;
            end else begin
                val = mem[ra];
            end
        end
        return val;
    endfunction

    assign rd1    = read_port(ra1, BYPASS);
    assign rd2    = read_port(ra2, BYPASS);
    assign dbg_rd = read_port(dbg_ra, 1'b0);

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - directed self-checking bench for register_file_2r1w
module tb_register_file_2r1w;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  dbg_ra;
    logic [31:0] dbg_rd;
    logic [15:0] wr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    register_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .dbg_ra (dbg_ra),
        .dbg_rd (dbg_rd),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a write after the falling edge, let one rising edge commit it, then drop we.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        wa = a;
        wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        we     = 1'b0;
        wa     = '0;
        wd     = '0;
        ra1    = 5'd5;
        ra2    = 5'd31;
        dbg_ra = '0;
        #1;
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        check("reset_cnt", {16'h0, wr_cnt}, 32'h0);

        // Writes presented during reset are ignored and not forwarded.
        @(negedge clk);
        we = 1'b1; wa = 5'd4; wd = 32'hCAFEF00D; ra1 = 5'd4; dbg_ra = 5'd4;
        #1;
        check("reset_no_bypass", rd1, 32'h0);
        @(posedge clk);
        #1;
        check("reset_no_write", dbg_rd, 32'h0);
        check("reset_no_cnt", {16'h0, wr_cnt}, 32'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;

        do_write(5'd8, 32'hDEADBEEF);
        ra1 = 5'd8;
        #1;
        check("wr_rd1", rd1, 32'hDEADBEEF);
        check("wr_cnt1", {16'h0, wr_cnt}, 32'h1);

        // Write to entry 0 is dropped, even while forwarding is live.
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd0;
        #1;
        check("zero_bypass", rd1, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("zero_rd1", rd1, 32'h0);
        check("zero_cnt", {16'h0, wr_cnt}, 32'h1);

        do_write(5'd9, 32'h1);
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; ra1 = 5'd9; ra2 = 5'd9; dbg_ra = 5'd9;
        #1;
        check("byp_rd1", rd1, 32'hA5A5A5A5);
        check("byp_rd2", rd2, 32'hA5A5A5A5);
        check("byp_dbg_old", dbg_rd, 32'h1);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("byp_dbg_new", dbg_rd, 32'hA5A5A5A5);
        check("byp_cnt", {16'h0, wr_cnt}, 32'h3);

        // Forwarding applies only to the port whose address matches.
        @(negedge clk);
        we = 1'b1; wa = 5'd10; wd = 32'h00000077; ra1 = 5'd10; ra2 = 5'd8;
        #1;
        check("indep_rd1", rd1, 32'h00000077);
        check("indep_rd2", rd2, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        we = 1'b0;

        do_write(5'd3, 32'hFF);
        dbg_ra = 5'd3;
        #1;
        check("pre_async_dbg", dbg_rd, 32'hFF);

        // Reset pulse between edges, with a write pending.
        @(negedge clk);
        we = 1'b1; wa = 5'd12; wd = 32'h55; ra1 = 5'd8;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_dbg", dbg_rd, 32'h0);
        check("async_rd1", rd1, 32'h0);
        check("async_cnt", {16'h0, wr_cnt}, 32'h0);
        #1;
        rst_n = 1'b1;
        we = 1'b0;
        dbg_ra = 5'd12;
        @(posedge clk);
        #1;
        check("async_write_dropped", dbg_rd, 32'h0);
        check("async_cnt_after", {16'h0, wr_cnt}, 32'h0);

        // Counter wrap: 65535 writes then one more.
        @(negedge clk);
        we = 1'b1; wa = 5'd1; wd = 32'h11;
        repeat (65535) @(posedge clk);
        #1;
        we = 1'b0;
        check("cnt_ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
        do_write(5'd1, 32'h22);
        dbg_ra = 5'd1;
        #1;
        check("cnt_wrap", {16'h0, wr_cnt}, 32'h0);
        check("wrap_data", dbg_rd, 32'h22);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
